hough_uart_ctrl: RTL and testbench
==================================

# hough_uart_ctrl

Frame-level sequencer between the UART byte stream and the `hough_transform` core.
- Receives a header plus a 16×16 binary image (32 bytes) from the UART RX path and writes it into the core's image memory.
- Pulses `start`, waits for `done`, snapshots the detected-line results and streams a fixed-length response frame to the UART TX path.
- One frame in flight at a time; bytes arriving outside image reception are dropped and flagged.

## Interface

Parameters
- `IMG_BYTES`, 32: image payload bytes per frame; core address range 0..IMG_BYTES-1.
- `MAX_LINES`, 4: line slots reported by the core; fixes response length at 2+3·MAX_LINES bytes.
- `HDR_RX`, 8'hA5: request header byte.
- `HDR_TX`, 8'h5A: response header byte.
- `TIMEOUT_CYCLES`, 500000: inter-byte timeout during reception (used only with `HOUGH_CTRL_TIMEOUT_EN`).

Ports
- `clk` in 1: single clock for the block and the core.
- `reset_n` in 1: synchronous, active-low reset.
- `rx_valid` in 1: one-cycle strobe per received byte; no backpressure.
- `rx_data` in 8: received byte, valid with `rx_valid`.
- `tx_valid` out 1: response byte available.
- `tx_data` out 8: response byte.
- `tx_ready` in 1: TX can accept; a transfer occurs when `tx_valid && tx_ready`.
- `h_wr_en` out 1: core image write enable.
- `h_wr_addr` out 8: core image byte address.
- `h_wr_data` out 8: core image byte data.
- `h_start` out 1: one-cycle start pulse to the core.
- `h_done` in 1: core completion, sampled as a level.
- `h_busy` in 1: core busy.
- `h_num_lines` in 8: number of lines detected by the core.
- `h_rho_flat` in 8·MAX_LINES: per-slot rho; slot i in bits [8i+7:8i].
- `h_theta_flat` in 8·MAX_LINES: per-slot theta, same packing.
- `h_votes_flat` in 8·MAX_LINES: per-slot votes, same packing.
- `ctrl_busy` out 1: high in every state except IDLE.
- `frame_count` out 8: completed response frames; wraps at 255→0.
- `err_overrun` out 1: sticky; byte dropped outside RX_IMG/IDLE.
- `err_timeout` out 1: sticky; reception aborted on timeout. Tied 0 without the macro.

## Operation

States and transitions:
- **IDLE**
  - `rx_valid && rx_data==HDR_RX` → RX_IMG; clears `err_overrun`, `err_timeout`, byte counter.
  - Any other byte is ignored, with no flag.
- **RX_IMG**
  - Each `rx_valid` drives `h_wr_en=1`, `h_wr_addr=count`, `h_wr_data=rx_data` on the next cycle, then increments `count`.
  - After byte IMG_BYTES-1 is written → START.
  - Header values inside the payload are treated as data.
- **START**
  - Holds unless `h_busy==0`.
  - Asserts `h_start` for exactly one cycle → WAIT_DONE.
- **WAIT_DONE**
  - On the first cycle `h_done==1`: snapshot `h_num_lines` and all flat buses into internal registers → TX.
  - `h_done` already high on entry must not be accepted. Only `h_done` sampled at least 2 cycles after `h_start` counts.
- **TX**
  - Byte order: HDR_TX, num_lines, then for i=0..MAX_LINES-1: rho[i], theta[i], votes[i].
  - Slots with i ≥ num_lines are sent as 0.
  - `tx_data` is stable while `tx_valid && !tx_ready`.
  - After the last accepted byte: `frame_count++` → IDLE.

Boundary conditions:
- `rx_valid` in START/WAIT_DONE/TX: byte dropped, `err_overrun=1`.
- `num_lines > MAX_LINES`: reported verbatim; all slots are sent from the snapshot.
- Reset mid-frame: immediate return to IDLE and all outputs to reset values. Partial image bytes already written are not cleared.

## Timing

- Reset values: `tx_valid`, `tx_data`, `h_wr_en`, `h_wr_addr`, `h_wr_data`, `h_start`, `ctrl_busy`, `frame_count`, `err_overrun`, `err_timeout` are all 0.
- Write latency: `rx_valid` at cycle n → `h_wr_en` at cycle n+1.
- `h_start` is asserted 1 cycle after the last write when `h_busy==0`.
- The TX state is entered 1 cycle after `h_done` is sampled. `tx_valid` rises on that entry cycle.
- With `tx_ready` held at 1, one byte is transferred per cycle (14 cycles for MAX_LINES=4).

## Configuration

- `HOUGH_CTRL_TIMEOUT_EN` defined:
  - In RX_IMG, a counter resets on each `rx_valid`.
  - When it reaches TIMEOUT_CYCLES: `err_timeout=1` → IDLE. `h_start` is not issued and no response is sent.
- Not defined: no counter; RX_IMG waits indefinitely; `err_timeout` is constant 0.

## Test plan

- Header A5 plus a vertical-line image at x=8, `h_done` modelled 100 cycles after start:
  - 32 writes with addr 0..31 matching the bytes, one `h_start` pulse.
  - TX frame 5A, then num_lines, then 12 slot bytes matching the model; `frame_count=1`.
- Header A5 plus an empty image, core returns num_lines=0: TX frame is 5A followed by 13 zero bytes.
- `tx_ready` toggled 1010… during TX: no byte lost or duplicated; `tx_data` stable while stalled.
- Byte 33 injected during WAIT_DONE: `err_overrun=1`, no extra write; the flag clears on the next A5 header.
- `reset_n` low for 1 cycle at byte 10 of reception, then a full new frame: all outputs 0 after reset; the new frame completes normally.
- With `HOUGH_CTRL_TIMEOUT_EN` and TIMEOUT_CYCLES=100, stop after 5 bytes: `err_timeout=1` after 100 idle cycles, no `h_start`, state IDLE.

Source files
------------

// File: rtl/hough_uart_ctrl.sv
// Frame sequencer between the UART byte stream and the hough_transform core.
// Optional inter-byte receive timeout is enabled with HOUGH_CTRL_TIMEOUT_EN.
module hough_uart_ctrl #(
  parameter int unsigned IMG_BYTES      = 32,
  parameter int unsigned MAX_LINES      = 4,
  parameter logic [7:0]  HDR_RX         = 8'hA5,
  parameter logic [7:0]  HDR_TX         = 8'h5A,
  parameter int unsigned TIMEOUT_CYCLES = 500000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  output logic                   tx_valid,
  output logic [7:0]             tx_data,
  input  logic                   tx_ready,
  output logic                   h_wr_en,
  output logic [7:0]             h_wr_addr,
  output logic [7:0]             h_wr_data,
  output logic                   h_start,
  input  logic                   h_done,
  input  logic                   h_busy,
  input  logic [7:0]             h_num_lines,
  input  logic [8*MAX_LINES-1:0] h_rho_flat,
  input  logic [8*MAX_LINES-1:0] h_theta_flat,
  input  logic [8*MAX_LINES-1:0] h_votes_flat,
  output logic                   ctrl_busy,
  output logic [7:0]             frame_count,
  output logic                   err_overrun,
  output logic                   err_timeout
);

  localparam int unsigned RESP_LEN = 2 + 3 * MAX_LINES;
  localparam int unsigned IDX_W    = $clog2(RESP_LEN);
`ifdef HOUGH_CTRL_TIMEOUT_EN
  localparam int unsigned TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RX_IMG    = 3'd1,
    S_START     = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_TX        = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [7:0]             count_q, count_d;
  logic                   wr_en_q, wr_en_d;
  logic [7:0]             wr_addr_q, wr_addr_d;
  logic [7:0]             wr_data_q, wr_data_d;
  logic                   start_q, start_d;
  logic [1:0]             wait_cnt_q, wait_cnt_d;
  logic                   tx_valid_q, tx_valid_d;
  logic [7:0]             tx_data_q, tx_data_d;
  logic [IDX_W-1:0]       tx_idx_q, tx_idx_d;
  logic [7:0]             frame_count_q, frame_count_d;
  logic                   err_overrun_q, err_overrun_d;
  logic                   err_timeout_q, err_timeout_d;
  logic                   ctrl_busy_q, ctrl_busy_d;
  logic [7:0]             num_lines_q, num_lines_d;
  logic [8*MAX_LINES-1:0] rho_q, rho_d;
  logic [8*MAX_LINES-1:0] theta_q, theta_d;
  logic [8*MAX_LINES-1:0] votes_q, votes_d;
`ifdef HOUGH_CTRL_TIMEOUT_EN
  logic [TMO_W-1:0]       tmo_q, tmo_d;
`endif

  // Response byte at position idx; slots beyond the reported line count read as zero.
  function automatic logic [7:0] resp_byte(
    input logic [IDX_W-1:0]       idx,
    input logic [7:0]             nl,
    input logic [8*MAX_LINES-1:0] rho,
    input logic [8*MAX_LINES-1:0] theta,
    input logic [8*MAX_LINES-1:0] votes
  );
    logic [7:0] b;
    b = 8'h00;
    if (idx == IDX_W'(0)) begin
      b = HDR_TX;
    end else if (idx == IDX_W'(1)) begin
      b = nl;
    end else begin
      for (int i = 0; i < int'(MAX_LINES); i++) begin
        if (int'(nl) > i) begin
          if (idx == IDX_W'(2 + 3 * i)) begin
            b = rho[8*i +: 8];
          end else if (idx == IDX_W'(3 + 3 * i)) begin
            b = theta[8*i +: 8];
          end else if (idx == IDX_W'(4 + 3 * i)) begin
            b = votes[8*i +: 8];
          end else begin
            b = b;
          end
        end else begin
          b = b;
        end
      end
    end
    return b;
  endfunction

  // Next-state and next-output computation for the frame sequencer.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    start_d       = 1'b0;
    wait_cnt_d    = wait_cnt_q;
    tx_valid_d    = tx_valid_q;
    tx_data_d     = tx_data_q;
    tx_idx_d      = tx_idx_q;
    frame_count_d = frame_count_q;
    err_overrun_d = err_overrun_q;
    err_timeout_d = err_timeout_q;
    num_lines_d   = num_lines_q;
    rho_d         = rho_q;
    theta_d       = theta_q;
    votes_d       = votes_q;
`ifdef HOUGH_CTRL_TIMEOUT_EN
    tmo_d         = tmo_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (rx_valid && (rx_data == HDR_RX)) begin
          state_d       = S_RX_IMG;
          count_d       = 8'd0;
          err_overrun_d = 1'b0;
          err_timeout_d = 1'b0;
`ifdef HOUGH_CTRL_TIMEOUT_EN
          tmo_d         = '0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RX_IMG: begin
        if (rx_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = count_q;
          wr_data_d = rx_data;
          count_d   = count_q + 8'd1;
`ifdef HOUGH_CTRL_TIMEOUT_EN
          tmo_d     = '0;
`endif
          if (count_q == 8'(IMG_BYTES - 1)) begin
            state_d = S_START;
          end else begin
            state_d = S_RX_IMG;
          end
`ifdef HOUGH_CTRL_TIMEOUT_EN
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          err_timeout_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
`else
        end else begin
          state_d = S_RX_IMG;
`endif
        end
      end
      S_START: begin
        if (rx_valid) begin
          err_overrun_d = 1'b1;
        end else begin
          err_overrun_d = err_overrun_q;
        end
        if (!h_busy) begin
          start_d    = 1'b1;
          wait_cnt_d = 2'd0;
          state_d    = S_WAIT_DONE;
        end else begin
          state_d = S_START;
        end
      end
      S_WAIT_DONE: begin
        if (rx_valid) begin
          err_overrun_d = 1'b1;
        end else begin
          err_overrun_d = err_overrun_q;
        end
        // A done level left over from the previous run is ignored until the core has seen start.
        if (h_done && (wait_cnt_q == 2'd2)) begin
          num_lines_d = h_num_lines;
          rho_d       = h_rho_flat;
          theta_d     = h_theta_flat;
          votes_d     = h_votes_flat;
          tx_valid_d  = 1'b1;
          tx_data_d   = HDR_TX;
          tx_idx_d    = IDX_W'(0);
          state_d     = S_TX;
        end else if (wait_cnt_q != 2'd2) begin
          wait_cnt_d = wait_cnt_q + 2'd1;
        end else begin
          state_d = S_WAIT_DONE;
        end
      end
      S_TX: begin
        if (rx_valid) begin
          err_overrun_d = 1'b1;
        end else begin
          err_overrun_d = err_overrun_q;
        end
        if (tx_valid_q && tx_ready) begin
          if (tx_idx_q == IDX_W'(RESP_LEN - 1)) begin
            tx_valid_d    = 1'b0;
            tx_data_d     = 8'h00;
            frame_count_d = frame_count_q + 8'd1;
            state_d       = S_IDLE;
          end else begin
            tx_idx_d  = tx_idx_q + IDX_W'(1);
            tx_data_d = resp_byte(tx_idx_q + IDX_W'(1), num_lines_q, rho_q, theta_q, votes_q);
          end
        end else begin
          state_d = S_TX;
        end
      end
      default: begin
        state_d    = S_IDLE;
        tx_valid_d = 1'b0;
      end
    endcase

    ctrl_busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      count_q       <= 8'd0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= 8'd0;
      wr_data_q     <= 8'd0;
      start_q       <= 1'b0;
      wait_cnt_q    <= 2'd0;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= 8'd0;
      tx_idx_q      <= '0;
      frame_count_q <= 8'd0;
      err_overrun_q <= 1'b0;
      err_timeout_q <= 1'b0;
      ctrl_busy_q   <= 1'b0;
      num_lines_q   <= 8'd0;
      rho_q         <= '0;
      theta_q       <= '0;
      votes_q       <= '0;
`ifdef HOUGH_CTRL_TIMEOUT_EN
      tmo_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      start_q       <= start_d;
      wait_cnt_q    <= wait_cnt_d;
      tx_valid_q    <= tx_valid_d;
      tx_data_q     <= tx_data_d;
      tx_idx_q      <= tx_idx_d;
      frame_count_q <= frame_count_d;
      err_overrun_q <= err_overrun_d;
      err_timeout_q <= err_timeout_d;
      ctrl_busy_q   <= ctrl_busy_d;
      num_lines_q   <= num_lines_d;
      rho_q         <= rho_d;
      theta_q       <= theta_d;
      votes_q       <= votes_d;
`ifdef HOUGH_CTRL_TIMEOUT_EN
      tmo_q         <= tmo_d;
`endif
    end
  end

  assign tx_valid    = tx_valid_q;
  assign tx_data     = tx_data_q;
  assign h_wr_en     = wr_en_q;
  assign h_wr_addr   = wr_addr_q;
  assign h_wr_data   = wr_data_q;
  assign h_start     = start_q;
  assign ctrl_busy   = ctrl_busy_q;
  assign frame_count = frame_count_q;
  assign err_overrun = err_overrun_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_hough_uart_ctrl.sv
// Directed bench for hough_uart_ctrl with a behavioural core that raises done 100 cycles after start.
module tb_hough_uart_ctrl;
  localparam int ML  = 4;
  localparam int LEN = 2 + 3 * ML;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, rx_valid, tx_ready, tx_valid, h_wr_en, h_start;
  logic ctrl_busy, err_overrun, err_timeout;
  logic [7:0] rx_data, tx_data, h_wr_addr, h_wr_data, frame_count, h_num_lines;
  logic [8*ML-1:0] h_rho_flat, h_theta_flat, h_votes_flat;
  logic h_done = 1'b0;
  logic h_busy = 1'b0;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int start_cnt = 0;
  int core_cnt = 0;
  logic core_run = 1'b0;
  logic [7:0] img [32];
  logic [7:0] exp_q [$];

  hough_uart_ctrl #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset_n(reset_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .h_wr_en(h_wr_en), .h_wr_addr(h_wr_addr), .h_wr_data(h_wr_data),
    .h_start(h_start), .h_done(h_done), .h_busy(h_busy),
    .h_num_lines(h_num_lines), .h_rho_flat(h_rho_flat),
    .h_theta_flat(h_theta_flat), .h_votes_flat(h_votes_flat),
    .ctrl_busy(ctrl_busy), .frame_count(frame_count),
    .err_overrun(err_overrun), .err_timeout(err_timeout)
  );

  // Core model: counts writes and starts, done stays high until the next start.
  always @(posedge clk) begin
    if (h_wr_en) wr_cnt++;
    if (h_start) begin
      start_cnt++;
      core_run <= 1'b1;
      core_cnt <= 0;
      h_done   <= 1'b0;
      h_busy   <= 1'b1;
    end else if (core_run) begin
      if (core_cnt == 99) begin
        core_run <= 1'b0;
        h_done   <= 1'b1;
        h_busy   <= 1'b0;
      end else begin
        core_cnt <= core_cnt + 1;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit chk, input int idx);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    if (chk) begin
      check_eq($sformatf("wr_en%0d", idx), h_wr_en, 1);
      check_eq($sformatf("wr_addr%0d", idx), h_wr_addr, idx);
      check_eq($sformatf("wr_data%0d", idx), h_wr_data, b);
    end
  endtask

  task automatic send_frame();
    int w0, s0;
    w0 = wr_cnt;
    s0 = start_cnt;
    send_byte(8'hA5, 1'b0, 0);
    check_eq("hdr_busy", ctrl_busy, 1);
    check_eq("hdr_ovr_clr", err_overrun, 0);
    for (int i = 0; i < 32; i++) send_byte(img[i], 1'b1, i);
    @(negedge clk);
    check_eq("start_hi", h_start, 1);
    @(negedge clk);
    check_eq("start_lo", h_start, 0);
    check_eq("wr_total", wr_cnt - w0, 32);
    check_eq("start_once", start_cnt - s0, 1);
  endtask

  task automatic recv_frame(input bit toggle);
    int got, first, last;
    bit stalled;
    logic [7:0] held;
    got = 0; first = 0; last = 0; stalled = 1'b0; held = 8'h00;
    exp_q = {};
    exp_q.push_back(8'h5A);
    exp_q.push_back(h_num_lines);
    for (int i = 0; i < ML; i++) begin
      if (i < int'(h_num_lines)) begin
        exp_q.push_back(h_rho_flat[8*i +: 8]);
        exp_q.push_back(h_theta_flat[8*i +: 8]);
        exp_q.push_back(h_votes_flat[8*i +: 8]);
      end else begin
        repeat (3) exp_q.push_back(8'h00);
      end
    end
    for (int c = 0; c < 3000 && got < LEN; c++) begin
      @(negedge clk);
      tx_ready = toggle ? ((c % 2) == 0) : 1'b1;
      if (tx_valid) begin
        if (stalled) check_eq("tx_stable", tx_data, held);
        if (tx_ready) begin
          check_eq($sformatf("tx_byte%0d", got), tx_data, exp_q[got]);
          if (got == 0) first = c;
          last = c;
          got++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = tx_data;
        end
      end
    end
    check_eq("tx_len", got, LEN);
    if (!toggle) check_eq("tx_span", last - first, LEN - 1);
    @(negedge clk);
    check_eq("tx_idle", tx_valid, 0);
    check_eq("busy_idle", ctrl_busy, 0);
  endtask

  task automatic check_reset_outs();
    check_eq("rst_tx_valid", tx_valid, 0);
    check_eq("rst_tx_data", tx_data, 0);
    check_eq("rst_wr_en", h_wr_en, 0);
    check_eq("rst_wr_addr", h_wr_addr, 0);
    check_eq("rst_wr_data", h_wr_data, 0);
    check_eq("rst_start", h_start, 0);
    check_eq("rst_busy", ctrl_busy, 0);
    check_eq("rst_fc", frame_count, 0);
    check_eq("rst_ovr", err_overrun, 0);
    check_eq("rst_tmo", err_timeout, 0);
  endtask

  initial begin
    int w0;
    reset_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
    h_num_lines = 8'd0; h_rho_flat = '0; h_theta_flat = '0; h_votes_flat = '0;
    repeat (3) @(negedge clk);
    check_reset_outs();
    reset_n = 1'b1;

    // Non-header byte in IDLE is ignored silently.
    send_byte(8'h33, 1'b0, 0);
    check_eq("idle_ignore_busy", ctrl_busy, 0);
    check_eq("idle_ignore_ovr", err_overrun, 0);

    // Frame 1: vertical line at x=8 (bit 0 of the right-hand byte of each row).
    for (int r = 0; r < 16; r++) begin
      img[2*r]   = 8'h00;
      img[2*r+1] = 8'h01;
    end
    h_num_lines  = 8'd1;
    h_rho_flat   = 32'h33221108;
    h_theta_flat = 32'h66554400;
    h_votes_flat = 32'h99887710;
    send_frame();
    recv_frame(1'b0);
    check_eq("fc1", frame_count, 1);

    // Frame 2: empty image, no lines, stale data on slot buses, stalling TX.
    for (int i = 0; i < 32; i++) img[i] = 8'h00;
    h_num_lines  = 8'd0;
    h_rho_flat   = 32'hDEADBEEF;
    h_theta_flat = 32'hCAFEF00D;
    h_votes_flat = 32'h12345678;
    send_frame();
    recv_frame(1'b1);
    check_eq("fc2", frame_count, 2);

    // Frame 3: header value inside payload, overrun during WAIT_DONE, num_lines above MAX_LINES.
    for (int i = 0; i < 32; i++) img[i] = 8'(i * 7);
    img[3] = 8'hA5;
    h_num_lines  = 8'd6;
    h_rho_flat   = 32'h44332211;
    h_theta_flat = 32'h88776655;
    h_votes_flat = 32'hCCBBAA99;
    send_frame();
    repeat (10) @(negedge clk);
    w0 = wr_cnt;
    send_byte(8'h21, 1'b0, 0);
    check_eq("ovr_no_wr_en", h_wr_en, 0);
    check_eq("ovr_set", err_overrun, 1);
    check_eq("ovr_no_write", wr_cnt - w0, 0);
    recv_frame(1'b0);
    check_eq("fc3", frame_count, 3);
    check_eq("ovr_sticky", err_overrun, 1);

    // Frame 4: the header clears the sticky flag.
    h_num_lines  = 8'd2;
    h_rho_flat   = 32'h0A0B0C0D;
    h_theta_flat = 32'h1A1B1C1D;
    h_votes_flat = 32'h2A2B2C2D;
    send_frame();
    recv_frame(1'b1);
    check_eq("fc4", frame_count, 4);

    // Reset in the middle of reception, then a complete frame.
    send_byte(8'hA5, 1'b0, 0);
    for (int i = 0; i < 10; i++) send_byte(img[i], 1'b1, i);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check_reset_outs();
    h_num_lines  = 8'd4;
    h_rho_flat   = 32'h04030201;
    h_theta_flat = 32'h14131211;
    h_votes_flat = 32'h24232221;
    send_frame();
    recv_frame(1'b0);
    check_eq("fc_after_rst", frame_count, 1);

`ifdef HOUGH_CTRL_TIMEOUT_EN
    begin
      int s0;
      s0 = start_cnt;
      send_byte(8'hA5, 1'b0, 0);
      for (int i = 0; i < 5; i++) send_byte(img[i], 1'b1, i);
      repeat (90) @(negedge clk);
      check_eq("tmo_not_yet", err_timeout, 0);
      repeat (15) @(negedge clk);
      check_eq("tmo_set", err_timeout, 1);
      check_eq("tmo_idle", ctrl_busy, 0);
      check_eq("tmo_no_start", start_cnt - s0, 0);
      check_eq("tmo_no_tx", tx_valid, 0);
    end
`else
    check_eq("tmo_tied0", err_timeout, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
